spi_reg_slave: RTL and testbench
================================

# spi_reg_slave

Parametrised SPI mode-0 slave with an addressed register interface. It replaces fixed-sequence 64-bit frame capture with header-addressed read and write transactions of configurable data width. It sits between the external SPI pins and the core's register file (key, data, control, result, status) inside the top-level module. The block oversamples SCLK in the system clock domain, so it has a single clock.

## Interface
Parameters:
- DATA_W, 64: data bits per frame, 8..128
- ADDR_W, 2: register address bits, 1..7
- SYNC_STAGES, 2: synchroniser depth for sclk, cs_n and mosi, at least 2

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- sclk  in  1  SPI clock, asynchronous to clk, idles low
- cs_n  in  1  SPI chip select, active low, asynchronous
- mosi  in  1  SPI data in, asynchronous
- miso  out  1  SPI data out; 0 when not shifting read data
- wr_en  out  1  one-cycle write strobe
- wr_addr  out  ADDR_W  write address, held until the next write
- wr_data  out  DATA_W  write data, held until the next write
- rd_addr  out  ADDR_W  read address, held until the next read
- rd_data  in  DATA_W  register contents at rd_addr; must be valid 1 clk after rd_addr changes
- busy  out  1  high while state is not IDLE
- frame_err  out  1  one-cycle strobe on abort or overrun

## Operation
- Input path:
  - sclk, cs_n and mosi each pass through SYNC_STAGES flops, so all three keep the same relative alignment.
  - A further flop on sclk and on cs_n provides edge detection: sclk_rise, sclk_fall, cs_fall, cs_rise.
- Frame format, MSB first: an 8-bit header followed by DATA_W data bits.
  - Header bit 7: 1 = read, 0 = write.
  - Header bits [ADDR_W-1:0]: address. Remaining header bits are ignored.
- bit_cnt counts sclk_rise events within the frame. Width is clog2(8+DATA_W+1).
- States:
  - IDLE: go to HEADER on cs_fall and clear bit_cnt. A cs_n that is already low at reset release is ignored until cs_n goes high and then low again.
  - HEADER: on each sclk_rise, shift in mosi. On the 8th rise, decode the header:
    - Read: go to RDATA and load rd_addr on the next clk.
    - Write: go to WDATA.
  - WDATA: on each sclk_rise, shift in mosi. On rise number 8+DATA_W: register wr_addr and wr_data, pulse wr_en on the following clk, then go to DONE.
  - RDATA:
    - The shift register loads rd_data 2 clk after the 8th-rise detect cycle.
    - On each sclk_fall, drive miso with the shift-register MSB and then shift left. The first fall after the load drives data bit DATA_W-1.
    - After rise number 8+DATA_W, go to DONE.
  - DONE: on cs_rise, go to IDLE. The first extra sclk_rise pulses frame_err once; all later edges are ignored.
- Abort: cs_rise in HEADER, WDATA or RDATA pulses frame_err, goes to IDLE, and suppresses wr_en. wr_addr and wr_data keep their previous values.
- Priority rules:
  - cs_rise wins over sclk_rise in the same cycle.
  - rst wins over everything.
- miso:
  - Driven 0 in IDLE, HEADER and WDATA.
  - In RDATA and DONE it holds the last driven bit until cs_rise, then returns to 0 on the next clk.

## Timing
- Reset values: miso 0, wr_en 0, wr_addr 0, wr_data 0, rd_addr 0, busy 0, frame_err 0; state IDLE; bit_cnt 0; shift register 0.
- Reset mid-frame: returns to IDLE immediately, with no wr_en and no frame_err.
- Edge-detect latency: SYNC_STAGES+1 clk from the pin edge to the detect cycle.
- Write latency: wr_en asserts 1 clk after the detect cycle of the final sclk_rise. It lasts exactly 1 clk.
- Read fetch: rd_addr updates 1 clk after the 8th-rise detect; the shift register loads 1 clk later.
- Minimum sclk half-period: SYNC_STAGES+3 clk cycles, which is 5 at the default setting.
  - This ensures miso changes before the master's next rising edge.
  - It ensures the read load completes before the first data-phase falling edge.
- Minimum cs_n high time between frames: SYNC_STAGES+2 clk.
- busy rises 1 clk after cs_fall detect and falls 1 clk after cs_rise detect (or after an abort).

## Test plan
- Write: header 0x02 with data 0x752878397493CB70 -> exactly one wr_en pulse, wr_addr=2, wr_data=0x752878397493CB70, frame_err stays 0.
- Read: rd_data=0xB5219EE81AA7499D when rd_addr==1; header 0x81 -> rd_addr=1, master captures 0xB5219EE81AA7499D, no wr_en, miso is 0 during the header.
- Abort: write header 0x03, cs_n raised after 40 total bits -> no wr_en, one frame_err pulse. A following full write to address 3 of 0x1122334455667788 succeeds.
- Overrun: write frame with 80 sclk cycles -> wr_en once after bit 72, one frame_err pulse at bit 73, return to IDLE on cs_n high.
- Reset mid-frame: rst for 1 clk at bit 20 while cs_n is held low, then 60 more sclk cycles -> no wr_en and no frame_err. After cs_n goes high then low, a new write to address 0 succeeds.
- Parameters: DATA_W=32, ADDR_W=3, with a loopback register file -> write 0xDEADBEEF to address 5, then read address 5 -> 0xDEADBEEF. Also check minimum-timing sclk (half-period of 5 clk).

Source files
------------

// File: rtl/spi_reg_slave.sv
// -----------------------------------------------------------------------------
// spi_reg_slave
//
// SPI mode-0 slave with an addressed register interface. The SPI pins are
// oversampled in the clk domain, so the block has a single clock.
//
// Each frame is MSB first: an 8-bit header followed by DATA_W data bits.
// Header bit 7 selects read (1) or write (0). Header bits [ADDR_W-1:0] give
// the register address, and the remaining header bits are ignored.
//
// Parameters
//   DATA_W       data bits per frame (8..128)
//   ADDR_W       register address bits (1..7)
//   SYNC_STAGES  synchroniser depth for sclk, cs_n and mosi (>= 2)
//
// Ports
//   clk        system clock, the only clock
//   rst        synchronous active-high reset
//   sclk       SPI clock, asynchronous to clk, idles low
//   cs_n       SPI chip select, active low, asynchronous
//   mosi       SPI data in, asynchronous
//   miso       SPI data out; 0 unless read data is being shifted out
//   wr_en      one-cycle write strobe
//   wr_addr    write address, held until the next write
//   wr_data    write data, held until the next write
//   rd_addr    read address, held until the next read
//   rd_data    register contents at rd_addr, valid 1 clk after rd_addr changes
//   busy       high while a frame is in progress
//   frame_err  one-cycle strobe on abort or overrun
// -----------------------------------------------------------------------------
module spi_reg_slave #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(8 + DATA_W + 1);

  // Count value at the 8th rise and at the final rise of a frame.
  localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(7);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(8 + DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    WDATA,
    RDATA,
    DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cs_d;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;
  logic cs_rise;

  // NOTE: the chip-select chain resets to 0, not to the idle-high level. A
  // cs_n that is already low when reset releases then produces no falling
  // edge, and only a fresh high-then-low sequence starts a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  // All three chains have the same depth, so mosi_s is the data bit that
  // belongs to the sclk edge seen on sclk_s.
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  // ---------------------------------------------------------------------------
  // Frame state and registered outputs
  // ---------------------------------------------------------------------------
  state_t              state;
  state_t              state_n;
  logic [CNT_W-1:0]    bit_cnt;
  logic [CNT_W-1:0]    bit_cnt_n;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   shreg_n;
  logic [DATA_W-1:0]   shift_in;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   addr_n;
  logic                load_pend;
  logic                load_pend_n;
  logic                ovr_seen;
  logic                ovr_seen_n;
  logic                miso_n;
  logic                wr_en_n;
  logic [ADDR_W-1:0]   wr_addr_n;
  logic [DATA_W-1:0]   wr_data_n;
  logic [ADDR_W-1:0]   rd_addr_n;
  logic                frame_err_n;

  // The header is collected in the low byte of the shift register, and the
  // data bits push it out the top, so after the final rise the register holds
  // exactly the data word.
  assign shift_in = {shreg[DATA_W-2:0], mosi_s};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      addr_q    <= '0;
      load_pend <= 1'b0;
      ovr_seen  <= 1'b0;
      miso      <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_addr   <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      addr_q    <= addr_n;
      load_pend <= load_pend_n;
      ovr_seen  <= ovr_seen_n;
      miso      <= miso_n;
      wr_en     <= wr_en_n;
      wr_addr   <= wr_addr_n;
      wr_data   <= wr_data_n;
      rd_addr   <= rd_addr_n;
      frame_err <= frame_err_n;
    end
  end

  // NOTE: every signal driven here gets its default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    addr_n      = addr_q;
    load_pend_n = 1'b0;
    ovr_seen_n  = ovr_seen;
    miso_n      = miso;
    wr_en_n     = 1'b0;
    wr_addr_n   = wr_addr;
    wr_data_n   = wr_data;
    rd_addr_n   = rd_addr;
    frame_err_n = 1'b0;

    case (state)
      IDLE: begin
        miso_n = 1'b0;
        if (cs_fall) begin
          state_n    = HEADER;
          bit_cnt_n  = '0;
          ovr_seen_n = 1'b0;
        end
      end

      HEADER: begin
        miso_n = 1'b0;
        // Chip select rising mid-frame wins over a coincident sclk edge.
        if (cs_rise) begin
          state_n     = IDLE;
          frame_err_n = 1'b1;
        end else if (sclk_rise) begin
          shreg_n   = shift_in;
          bit_cnt_n = bit_cnt + CNT_W'(1);
          if (bit_cnt == HDR_LAST) begin
            addr_n = shift_in[ADDR_W-1:0];
            if (shift_in[7]) begin
              // Read: present the address now, and capture rd_data one
              // clk later once the register file has had a cycle to respond.
              state_n     = RDATA;
              rd_addr_n   = shift_in[ADDR_W-1:0];
              load_pend_n = 1'b1;
            end else begin
              state_n = WDATA;
            end
          end
        end
      end

      WDATA: begin
        miso_n = 1'b0;
        if (cs_rise) begin
          // Aborted writes leave wr_addr and wr_data untouched.
          state_n     = IDLE;
          frame_err_n = 1'b1;
        end else if (sclk_rise) begin
          shreg_n   = shift_in;
          bit_cnt_n = bit_cnt + CNT_W'(1);
          if (bit_cnt == FRAME_LAST) begin
            state_n   = DONE;
            wr_en_n   = 1'b1;
            wr_addr_n = addr_q;
            wr_data_n = shift_in;
          end
        end
      end

      RDATA: begin
        if (cs_rise) begin
          state_n     = IDLE;
          frame_err_n = 1'b1;
          miso_n      = 1'b0;
        end else begin
          if (load_pend) begin
            shreg_n = rd_data;
          end else if (sclk_fall) begin
            // Mode 0: change miso after the falling edge so the master
            // samples a stable bit on the next rising edge.
            miso_n  = shreg[DATA_W-1];
            shreg_n = {shreg[DATA_W-2:0], 1'b0};
          end
          if (sclk_rise) begin
            bit_cnt_n = bit_cnt + CNT_W'(1);
            if (bit_cnt == FRAME_LAST) begin
              state_n = DONE;
            end
          end
        end
      end

      DONE: begin
        if (cs_rise) begin
          state_n = IDLE;
          miso_n  = 1'b0;
        end else if (sclk_rise && !ovr_seen) begin
          // Only the first surplus clock is reported; the rest are ignored.
          frame_err_n = 1'b1;
          ovr_seen_n  = 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        miso_n  = 1'b0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_slave
//
// Drives two instances of spi_reg_slave from a behavioural SPI master: the
// default 64-bit/2-bit-address build, and a 32-bit/3-bit-address build. Each
// instance has its own loopback register file. The two instances share sclk
// and mosi but have separate chip selects. Expected register contents come
// from a bench-side model that is updated from the frames the master sends.
// -----------------------------------------------------------------------------
module tb_spi_reg_slave;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic sclk   = 1'b0;
  logic mosi   = 1'b0;
  logic cs_n64 = 1'b1;
  logic cs_n32 = 1'b1;

  always #5 clk = ~clk;

  logic        miso64, wr_en64, busy64, ferr64;
  logic [1:0]  wr_addr64, rd_addr64;
  logic [63:0] wr_data64, rd_data64;

  logic        miso32, wr_en32, busy32, ferr32;
  logic [2:0]  wr_addr32, rd_addr32;
  logic [31:0] wr_data32, rd_data32;

  spi_reg_slave dut64 (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n64),
    .mosi      (mosi),
    .miso      (miso64),
    .wr_en     (wr_en64),
    .wr_addr   (wr_addr64),
    .wr_data   (wr_data64),
    .rd_addr   (rd_addr64),
    .rd_data   (rd_data64),
    .busy      (busy64),
    .frame_err (ferr64)
  );

  spi_reg_slave #(
    .DATA_W (32),
    .ADDR_W (3)
  ) dut32 (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n32),
    .mosi      (mosi),
    .miso      (miso32),
    .wr_en     (wr_en32),
    .wr_addr   (wr_addr32),
    .wr_data   (wr_data32),
    .rd_addr   (rd_addr32),
    .rd_data   (rd_data32),
    .busy      (busy32),
    .frame_err (ferr32)
  );

  // Loopback register files written by the DUT's own strobes.
  logic [63:0] rf64 [4] = '{default: '0};
  logic [31:0] rf32 [8] = '{default: '0};
  assign rd_data64 = rf64[rd_addr64];
  assign rd_data32 = rf32[rd_addr32];

  // Reference model of register contents, updated from completed frames.
  logic [63:0] m64 [4] = '{default: '0};
  logic [31:0] m32 [8] = '{default: '0};

  int total = 0;
  int bad   = 0;
  int cur_bit = 0;

  int wr_cnt64 = 0, ferr_cnt64 = 0, wr_bit64 = -1, ferr_bit64 = -1;
  int wr_cnt32 = 0, ferr_cnt32 = 0;

  always @(posedge clk) begin
    if (wr_en64) begin
      rf64[wr_addr64] <= wr_data64;
      wr_cnt64        <= wr_cnt64 + 1;
      wr_bit64        <= cur_bit;
    end
    if (ferr64) begin
      ferr_cnt64 <= ferr_cnt64 + 1;
      ferr_bit64 <= cur_bit;
    end
    if (wr_en32) begin
      rf32[wr_addr32] <= wr_data32;
      wr_cnt32        <= wr_cnt32 + 1;
    end
    if (ferr32) begin
      ferr_cnt32 <= ferr_cnt32 + 1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // SPI mode-0 master. Sends bits[nbits-1] first, with each sclk half-period
  // lasting 'half' clk cycles. miso is sampled just before every rising edge.
  // If rst_at > 0, rst is pulsed for one clk right after that rising edge.
  task automatic spi_xfer(input bit sel32, input int nbits,
                          input logic [135:0] bits, input int half,
                          input int rst_at, output logic [135:0] rx,
                          output bit hdr_miso, output logic busy_mid);
    logic m;
    rx       = '0;
    hdr_miso = 1'b0;
    busy_mid = 1'b0;
    cur_bit  = 0;
    @(posedge clk); #1;
    if (sel32) cs_n32 = 1'b0; else cs_n64 = 1'b0;
    repeat (half) @(posedge clk);
    for (int i = 0; i < nbits; i++) begin
      #1 mosi = bits[nbits-1-i];
      repeat (half) @(posedge clk);
      #1;
      m  = sel32 ? miso32 : miso64;
      rx = {rx[134:0], m};
      if (i < 8 && m) hdr_miso = 1'b1;
      if (i == 4) busy_mid = sel32 ? busy32 : busy64;
      sclk    = 1'b1;
      cur_bit = i + 1;
      if (rst_at == i + 1) begin
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
      end
      repeat (half) @(posedge clk);
      #1 sclk = 1'b0;
    end
    repeat (half) @(posedge clk);
    #1;
    cs_n64 = 1'b1;
    cs_n32 = 1'b1;
    mosi   = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (miso64 !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b exp=0", miso64); end
    total++; if (wr_en64 !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", wr_en64); end
    total++; if (wr_addr64 !== 2'd0) begin bad++; $display("FAIL reset_wr_addr got=%h exp=0", wr_addr64); end
    total++; if (wr_data64 !== 64'd0) begin bad++; $display("FAIL reset_wr_data got=%h exp=0", wr_data64); end
    total++; if (rd_addr64 !== 2'd0) begin bad++; $display("FAIL reset_rd_addr got=%h exp=0", rd_addr64); end
    total++; if (busy64 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy64); end
    total++; if (ferr64 !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", ferr64); end
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    total++; if (busy64 !== 1'b0 || busy32 !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b%b exp=00", busy64, busy32); end
    total++; if (ferr_cnt64 != 0 || ferr_cnt32 != 0) begin bad++; $display("FAIL post_reset_frame_err got=%0d/%0d exp=0/0", ferr_cnt64, ferr_cnt32); end
  endtask

  task automatic test_write();
    logic [135:0] rx;
    bit hm;
    logic bm;
    int w0 = wr_cnt64;
    int f0 = ferr_cnt64;
    logic [63:0] d = 64'h752878397493CB70;
    spi_xfer(1'b0, 72, 136'({8'h02, d}), 5, 0, rx, hm, bm);
    m64[2] = d;
    total++; if (wr_cnt64 - w0 != 1) begin bad++; $display("FAIL write_count got=%0d exp=1", wr_cnt64 - w0); end
    total++; if (wr_addr64 !== 2'd2) begin bad++; $display("FAIL write_addr got=%h exp=2", wr_addr64); end
    total++; if (wr_data64 !== d) begin bad++; $display("FAIL write_data got=%h exp=%h", wr_data64, d); end
    total++; if (wr_bit64 != 72) begin bad++; $display("FAIL write_timing got=bit%0d exp=bit72", wr_bit64); end
    total++; if (ferr_cnt64 != f0) begin bad++; $display("FAIL write_frame_err got=%0d exp=0", ferr_cnt64 - f0); end
    total++; if (rx !== 136'd0) begin bad++; $display("FAIL write_miso_quiet got=%h exp=0", rx); end
    total++; if (bm !== 1'b1) begin bad++; $display("FAIL write_busy_mid got=%b exp=1", bm); end
    total++; if (busy64 !== 1'b0) begin bad++; $display("FAIL write_busy_end got=%b exp=0", busy64); end
  endtask

  task automatic test_read();
    logic [135:0] rx;
    bit hm;
    logic bm;
    int w0;
    int f0;
    logic [63:0] d = 64'hB5219EE81AA7499D;
    spi_xfer(1'b0, 72, 136'({8'h01, d}), 5, 0, rx, hm, bm);
    m64[1] = d;
    w0 = wr_cnt64;
    f0 = ferr_cnt64;
    spi_xfer(1'b0, 72, 136'({8'h81, 64'd0}), 5, 0, rx, hm, bm);
    total++; if (rd_addr64 !== 2'd1) begin bad++; $display("FAIL read_addr got=%h exp=1", rd_addr64); end
    total++; if (rx[63:0] !== m64[1]) begin bad++; $display("FAIL read_data got=%h exp=%h", rx[63:0], m64[1]); end
    total++; if (hm !== 1'b0) begin bad++; $display("FAIL read_header_miso got=%b exp=0", hm); end
    total++; if (wr_cnt64 != w0) begin bad++; $display("FAIL read_no_write got=%0d exp=0", wr_cnt64 - w0); end
    total++; if (ferr_cnt64 != f0) begin bad++; $display("FAIL read_frame_err got=%0d exp=0", ferr_cnt64 - f0); end
    total++; if (miso64 !== 1'b0) begin bad++; $display("FAIL read_miso_idle got=%b exp=0", miso64); end
  endtask

  task automatic test_abort();
    logic [135:0] rx;
    bit hm;
    logic bm;
    int w0 = wr_cnt64;
    int f0 = ferr_cnt64;
    logic [63:0] junk = {$urandom, $urandom};
    logic [63:0] d = 64'h1122334455667788;
    // Only the first 40 bits of a write to address 3 are sent.
    spi_xfer(1'b0, 40, 136'({8'h03, junk}) >> 32, 5, 0, rx, hm, bm);
    total++; if (wr_cnt64 != w0) begin bad++; $display("FAIL abort_no_write got=%0d exp=0", wr_cnt64 - w0); end
    total++; if (ferr_cnt64 - f0 != 1) begin bad++; $display("FAIL abort_frame_err got=%0d exp=1", ferr_cnt64 - f0); end
    total++; if (wr_addr64 !== 2'd1 || wr_data64 !== 64'hB5219EE81AA7499D) begin
      bad++; $display("FAIL abort_hold got=%h/%h exp=1/b5219ee81aa7499d", wr_addr64, wr_data64);
    end
    total++; if (busy64 !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy64); end
    w0 = wr_cnt64;
    f0 = ferr_cnt64;
    spi_xfer(1'b0, 72, 136'({8'h03, d}), 5, 0, rx, hm, bm);
    m64[3] = d;
    total++; if (wr_cnt64 - w0 != 1) begin bad++; $display("FAIL after_abort_count got=%0d exp=1", wr_cnt64 - w0); end
    total++; if (wr_addr64 !== 2'd3 || wr_data64 !== d) begin bad++; $display("FAIL after_abort_write got=%h/%h exp=3/%h", wr_addr64, wr_data64, d); end
    total++; if (ferr_cnt64 != f0) begin bad++; $display("FAIL after_abort_frame_err got=%0d exp=0", ferr_cnt64 - f0); end
  endtask

  task automatic test_overrun();
    logic [135:0] rx;
    bit hm;
    logic bm;
    int w0 = wr_cnt64;
    int f0 = ferr_cnt64;
    logic [63:0] d = {$urandom, $urandom};
    spi_xfer(1'b0, 80, 136'({8'h02, d, 8'hA5}), 5, 0, rx, hm, bm);
    m64[2] = d;
    total++; if (wr_cnt64 - w0 != 1) begin bad++; $display("FAIL overrun_write_count got=%0d exp=1", wr_cnt64 - w0); end
    total++; if (wr_bit64 != 72) begin bad++; $display("FAIL overrun_write_timing got=bit%0d exp=bit72", wr_bit64); end
    total++; if (wr_data64 !== d) begin bad++; $display("FAIL overrun_write_data got=%h exp=%h", wr_data64, d); end
    total++; if (ferr_cnt64 - f0 != 1) begin bad++; $display("FAIL overrun_frame_err_count got=%0d exp=1", ferr_cnt64 - f0); end
    total++; if (ferr_bit64 != 73) begin bad++; $display("FAIL overrun_frame_err_timing got=bit%0d exp=bit73", ferr_bit64); end
    total++; if (busy64 !== 1'b0) begin bad++; $display("FAIL overrun_busy got=%b exp=0", busy64); end
  endtask

  task automatic test_reset_mid_frame();
    logic [135:0] rx;
    bit hm;
    logic bm;
    int w0 = wr_cnt64;
    int f0 = ferr_cnt64;
    logic [63:0] d  = {$urandom, $urandom};
    logic [63:0] d2 = {$urandom, $urandom};
    spi_xfer(1'b0, 80, 136'({8'h01, d, 8'h00}), 5, 20, rx, hm, bm);
    total++; if (wr_cnt64 != w0) begin bad++; $display("FAIL rst_mid_no_write got=%0d exp=0", wr_cnt64 - w0); end
    total++; if (ferr_cnt64 != f0) begin bad++; $display("FAIL rst_mid_frame_err got=%0d exp=0", ferr_cnt64 - f0); end
    total++; if (wr_data64 !== 64'd0 || wr_addr64 !== 2'd0) begin bad++; $display("FAIL rst_mid_outputs got=%h/%h exp=0/0", wr_addr64, wr_data64); end
    spi_xfer(1'b0, 72, 136'({8'h00, d2}), 5, 0, rx, hm, bm);
    m64[0] = d2;
    total++; if (wr_cnt64 - w0 != 1) begin bad++; $display("FAIL rst_mid_recover_count got=%0d exp=1", wr_cnt64 - w0); end
    total++; if (wr_addr64 !== 2'd0 || wr_data64 !== d2) begin bad++; $display("FAIL rst_mid_recover_write got=%h/%h exp=0/%h", wr_addr64, wr_data64, d2); end
  endtask

  task automatic test_param();
    logic [135:0] rx;
    bit hm;
    logic bm;
    int w0 = wr_cnt32;
    int f0 = ferr_cnt32;
    spi_xfer(1'b1, 40, 136'({8'h05, 32'hDEADBEEF}), 5, 0, rx, hm, bm);
    m32[5] = 32'hDEADBEEF;
    total++; if (wr_cnt32 - w0 != 1) begin bad++; $display("FAIL param_write_count got=%0d exp=1", wr_cnt32 - w0); end
    total++; if (wr_addr32 !== 3'd5 || wr_data32 !== 32'hDEADBEEF) begin bad++; $display("FAIL param_write got=%h/%h exp=5/deadbeef", wr_addr32, wr_data32); end
    spi_xfer(1'b1, 40, 136'({8'h85, 32'h0}), 5, 0, rx, hm, bm);
    total++; if (rd_addr32 !== 3'd5) begin bad++; $display("FAIL param_read_addr got=%h exp=5", rd_addr32); end
    total++; if (rx[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL param_read_data got=%h exp=deadbeef", rx[31:0]); end
    total++; if (ferr_cnt32 != f0 || wr_cnt32 - w0 != 1) begin bad++; $display("FAIL param_side_effects got=%0d/%0d exp=0/1", ferr_cnt32 - f0, wr_cnt32 - w0); end
  endtask

  // Back-to-back random reads and writes on both builds. The header's unused
  // bits are random, and the address is taken from its low ADDR_W bits.
  task automatic test_back_to_back();
    logic [135:0] rx;
    bit hm;
    logic bm;
    for (int n = 0; n < 16; n++) begin
      bit          sel32 = 1'($urandom_range(0, 1));
      logic [7:0]  hdr   = 8'($urandom);
      logic [63:0] d     = {$urandom, $urandom};
      int          half  = $urandom_range(5, 7);
      int          a     = sel32 ? int'(hdr[2:0]) : int'(hdr[1:0]);
      int          w0    = sel32 ? wr_cnt32 : wr_cnt64;
      int          f0    = sel32 ? ferr_cnt32 : ferr_cnt64;
      int          nb    = sel32 ? 40 : 72;
      logic [135:0] bits = sel32 ? 136'({hdr, d[31:0]}) : 136'({hdr, d});
      spi_xfer(sel32, nb, bits, half, 0, rx, hm, bm);
      if (!hdr[7]) begin
        if (sel32) m32[a] = d[31:0]; else m64[a] = d;
        total++;
        if ((sel32 ? wr_cnt32 : wr_cnt64) - w0 != 1 ||
            (sel32 ? int'(wr_addr32) : int'(wr_addr64)) != a ||
            (sel32 ? {32'd0, wr_data32} : wr_data64) !== (sel32 ? {32'd0, d[31:0]} : d)) begin
          bad++;
          $display("FAIL rand_write[%0d] w32=%b got=%h/%h exp=%0d/%h", n, sel32,
                   sel32 ? int'(wr_addr32) : int'(wr_addr64),
                   sel32 ? {32'd0, wr_data32} : wr_data64, a, d);
        end
        total++; if (rx !== 136'd0) begin bad++; $display("FAIL rand_write_miso[%0d] got=%h exp=0", n, rx); end
      end else begin
        logic [63:0] exp_d = sel32 ? {32'd0, m32[a]} : m64[a];
        logic [63:0] got_d = sel32 ? {32'd0, rx[31:0]} : rx[63:0];
        total++;
        if (got_d !== exp_d || hm !== 1'b0) begin
          bad++;
          $display("FAIL rand_read[%0d] w32=%b addr=%0d got=%h hdr_miso=%b exp=%h hdr_miso=0", n, sel32, a, got_d, hm, exp_d);
        end
        total++;
        if ((sel32 ? int'(rd_addr32) : int'(rd_addr64)) != a || (sel32 ? wr_cnt32 : wr_cnt64) != w0) begin
          bad++;
          $display("FAIL rand_read_addr[%0d] got=%0d exp=%0d", n, sel32 ? int'(rd_addr32) : int'(rd_addr64), a);
        end
      end
      total++;
      if ((sel32 ? ferr_cnt32 : ferr_cnt64) != f0) begin
        bad++; $display("FAIL rand_frame_err[%0d] got=%0d exp=0", n, (sel32 ? ferr_cnt32 : ferr_cnt64) - f0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_overrun();
    test_reset_mid_frame();
    test_param();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
